mc_control_fsm: RTL and testbench

Parametrised multicycle MIPS control FSM, successor to the fixed-timing control module. Sits between the instruction register's opcode field and the multicycle datapath, sequencing fetch/decode/execute/memory/writeback. Adds configurable memory wait-states, BNE, illegal-opcode detection and an instruction-complete strobe.

---
 rtl/mc_control_fsm_pkg.sv | 75 +++++++
 rtl/mc_control_fsm_wait.sv | 31 +++
 rtl/mc_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// Holds state encodings, datapath mux/ALU encodings, opcodes and the control bundle.
// Optional feature macro: MIPS_IMM_OPS_EN adds the IMM_EX/IMM_WB states.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EX,
        R_WB,
        BRANCH,
`ifdef MIPS_IMM_OPS_EN
        JUMP,
        IMM_EX,
        IMM_WB
`else
        JUMP
`endif
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [2:0] SRCB_B       = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_SEXT    = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH = 3'b011;
    localparam logic [2:0] SRCB_ZEXT    = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic       pcWriteCond;
        logic       pcWrite;
        logic       iorD;
        logic       branchNE;
        logic [2:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       badOp;
    } ctrl_t;

    // Logical immediates take a zero-extended operand.
    function automatic logic isZeroExtOp(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_control_fsm_wait.sv
// mem_wait_ctr: wait-state counter for memory states of the control FSM.
// Ports: clk, rst (sync high), clear, enable in; last out (count==MEM_WAIT).
module mem_wait_ctr
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WAIT);

    logic [CNT_W-1:0] count;

    // Saturates at LAST_CNT so a stalled state never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_CNT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory wait-states, BNE, illegal-op detect.
// Ports: clk, rst (sync high), Op_code in; datapath controls, instr_done, bad_op out.
// Define MIPS_IMM_OPS_EN to build ADDI/ANDI/ORI/SLTI support.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op_code,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       BranchNE,
    output logic [2:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       bad_op
);

    state_t     state;
    state_t     nextState;
    logic [5:0] opLatch;
    logic       memState;
    logic       waitClr;
    logic       waitLast;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            opLatch <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opLatch <= Op_code;
            end
        end
    end

    assign memState = (state == FETCH) ||
                      (state == MEM_READ) ||
                      (state == MEM_WRITE);

    // Any state change restarts the count, so each memory state begins at 0.
    assign waitClr = (nextState != state);

    mem_wait_ctr #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_W    (CNT_W)
    ) uWait (
        .clk    (clk),
        .rst    (rst),
        .clear  (waitClr),
        .enable (memState),
        .last   (waitLast)
    );

    always_comb begin
        nextState = state;
        ctrl      = '0;
        unique case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                if (waitLast) begin
                    ctrl.irWrite = 1'b1;
                    ctrl.pcWrite = 1'b1;
                    nextState    = DECODE;
                end
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_SEXT_SH;
                case (Op_code)
                    OP_LW, OP_SW:   nextState = MEM_ADDR;
                    OP_RTYPE:       nextState = R_EX;
                    OP_BEQ, OP_BNE: nextState = BRANCH;
                    OP_J:           nextState = JUMP;
`ifdef MIPS_IMM_OPS_EN
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI: nextState = IMM_EX;
`endif
                    default: begin
                        ctrl.badOp     = 1'b1;
                        ctrl.instrDone = 1'b1;
                        nextState      = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_SEXT;
                nextState    = (opLatch == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
                if (waitLast) begin
                    nextState = MEM_WB;
                end
            end
            MEM_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memtoReg  = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            MEM_WRITE: begin
                ctrl.iorD = 1'b1;
                if (waitLast) begin
                    ctrl.memWrite  = 1'b1;
                    ctrl.instrDone = 1'b1;
                    nextState      = FETCH;
                end
            end
            R_EX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALU_FUNCT;
                nextState    = R_WB;
            end
            R_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PC_ALUOUT;
                ctrl.branchNE    = (opLatch == OP_BNE);
                ctrl.instrDone   = 1'b1;
                nextState        = FETCH;
            end
            JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSource  = PC_JUMP;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
`ifdef MIPS_IMM_OPS_EN
            IMM_EX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALU_IMM;
                ctrl.aluSrcB = isZeroExtOp(opLatch) ? SRCB_ZEXT : SRCB_SEXT;
                nextState    = IMM_WB;
            end
            IMM_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = FETCH;
            end
`endif
            default: nextState = FETCH;
        endcase
        // Reset cycle must not leak any write enable to the datapath.
        if (rst) begin
            ctrl = '0;
        end
    end

    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign RegDst      = ctrl.regDst;
    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign PCWrite     = ctrl.pcWrite;
    assign IorD        = ctrl.iorD;
    assign BranchNE    = ctrl.branchNE;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign instr_done  = ctrl.instrDone;
    assign bad_op      = ctrl.badOp;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: three instances at MEM_WAIT 0, 1, 2.
// Output vector: {MR,MW,IRW,M2R,RD,RW,ASA,PCWC,PCW,IorD, BNE, SrcB, ALUOp, PCSrc, done, bad}.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op  = 6'b000000;

    logic [2:0] memRead, memWrite, irWrite, memtoReg, regDst, regWrite;
    logic [2:0] aluSrcA, pcWriteCond, pcWrite, iorD, branchNE;
    logic [2:0] instrDone, badOp;
    logic [2:0] aluSrcB  [0:2];
    logic [1:0] aluOp    [0:2];
    logic [1:0] pcSource [0:2];
    logic [19:0] outv    [0:2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        mc_control_fsm #(.MEM_WAIT(g), .CNT_W(4)) dut (
            .clk         (clk),
            .rst         (rst),
            .Op_code     (op),
            .MemRead     (memRead[g]),
            .MemWrite    (memWrite[g]),
            .IRWrite     (irWrite[g]),
            .MemtoReg    (memtoReg[g]),
            .RegDst      (regDst[g]),
            .RegWrite    (regWrite[g]),
            .ALUSrcA     (aluSrcA[g]),
            .PCWriteCond (pcWriteCond[g]),
            .PCWrite     (pcWrite[g]),
            .IorD        (iorD[g]),
            .BranchNE    (branchNE[g]),
            .ALUSrcB     (aluSrcB[g]),
            .ALUOp       (aluOp[g]),
            .PCSource    (pcSource[g]),
            .instr_done  (instrDone[g]),
            .bad_op      (badOp[g])
        );
        assign outv[g] = {memRead[g], memWrite[g], irWrite[g], memtoReg[g],
                          regDst[g], regWrite[g], aluSrcA[g], pcWriteCond[g],
                          pcWrite[g], iorD[g], branchNE[g], aluSrcB[g],
                          aluOp[g], pcSource[g], instrDone[g], badOp[g]};
    end

    localparam logic [19:0] ZERO    = 20'b0;
    localparam logic [19:0] F_HOLD  = {10'b1000000000, 1'b0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] F_LAST  = {10'b1010000010, 1'b0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] DEC     = {10'b0000000000, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] DEC_BAD = {10'b0000000000, 1'b0, 3'b011, 2'b00, 2'b00, 1'b1, 1'b1};
    localparam logic [19:0] MADDR   = {10'b0000001000, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] MREAD   = {10'b1000000001, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] MWB     = {10'b0001010000, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] MW_HOLD = {10'b0000000001, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] MW_LAST = {10'b0100000001, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] REX     = {10'b0000001000, 1'b0, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] RWB     = {10'b0000110000, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [19:0] BR_NE   = {10'b0000001100, 1'b1, 3'b000, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [19:0] BR_EQ   = {10'b0000001100, 1'b0, 3'b000, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [19:0] JMP     = {10'b0000000010, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [19:0] IEX_S   = {10'b0000001000, 1'b0, 3'b010, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] IEX_Z   = {10'b0000001000, 1'b0, 3'b100, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [19:0] IWB     = {10'b0000010000, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};

    int nChk  = 0;
    int nFail = 0;

    logic [19:0] ev [0:15];
    int          n;

    task automatic put(input logic [19:0] v);
        ev[n] = v;
        n++;
    endtask

    // Pulse reset for one cycle, then release with the new opcode applied.
    task automatic restart(input logic [5:0] o);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op  = o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op  = 6'b000000;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            nChk++;
            if (outv[g] !== ZERO) begin
                nFail++;
                $display("FAIL reset_outputs dut%0d: got %b want %b", g, outv[g], ZERO);
            end
        end
    endtask

    task automatic test_rtype();
        n = 0;
        put(F_LAST); put(DEC); put(REX); put(RWB);
        put(F_LAST); put(DEC); put(REX); put(RWB);
        restart(6'b000000);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL rtype_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw();
        n = 0;
        put(F_HOLD); put(F_HOLD); put(F_LAST); put(DEC); put(MADDR);
        put(MREAD); put(MREAD); put(MREAD); put(MWB); put(F_HOLD);
        restart(6'b100011);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[2] !== ev[c]) begin
                nFail++;
                $display("FAIL lw_w2 cyc%0d: got %b want %b", c + 1, outv[2], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        n = 0;
        put(F_HOLD); put(F_LAST); put(DEC); put(MADDR);
        put(MW_HOLD); put(MW_LAST); put(F_HOLD);
        restart(6'b101011);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[1] !== ev[c]) begin
                nFail++;
                $display("FAIL sw_w1 cyc%0d: got %b want %b", c + 1, outv[1], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        n = 0;
        put(F_LAST); put(DEC); put(BR_NE); put(F_LAST);
        restart(6'b000101);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL bne_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
        n = 0;
        put(F_LAST); put(DEC); put(BR_EQ); put(F_LAST);
        restart(6'b000100);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL beq_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        n = 0;
        put(F_HOLD); put(F_LAST); put(DEC); put(JMP); put(F_HOLD);
        restart(6'b000010);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[1] !== ev[c]) begin
                nFail++;
                $display("FAIL jump_w1 cyc%0d: got %b want %b", c + 1, outv[1], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_op();
        n = 0;
        put(F_LAST); put(DEC_BAD); put(F_LAST); put(DEC_BAD);
        restart(6'b111111);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL badop_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
        n = 0;
        put(F_HOLD); put(F_LAST); put(DEC_BAD); put(F_HOLD);
        restart(6'b111111);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[1] !== ev[c]) begin
                nFail++;
                $display("FAIL badop_w1 cyc%0d: got %b want %b", c + 1, outv[1], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_imm();
        n = 0;
`ifdef MIPS_IMM_OPS_EN
        put(F_LAST); put(DEC); put(IEX_S); put(IWB); put(F_LAST);
`else
        put(F_LAST); put(DEC_BAD); put(F_LAST); put(DEC_BAD);
`endif
        restart(6'b001000);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL addi_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
        n = 0;
`ifdef MIPS_IMM_OPS_EN
        put(F_LAST); put(DEC); put(IEX_Z); put(IWB);
`else
        put(F_LAST); put(DEC_BAD); put(F_LAST);
`endif
        restart(6'b001101);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL ori_w0 cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        n = 0;
        put(F_LAST); put(DEC); put(REX);
        restart(6'b000000);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL rstmid_pre cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            if (c < n - 1) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        nChk++;
        if (outv[0] !== ZERO) begin
            nFail++;
            $display("FAIL rstmid_rex: got %b want %b", outv[0], ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        put(F_LAST); put(DEC); put(REX); put(RWB);
        for (int c = 0; c < n; c++) begin
            #1;
            nChk++;
            if (outv[0] !== ev[c]) begin
                nFail++;
                $display("FAIL rstmid_post cyc%0d: got %b want %b", c + 1, outv[0], ev[c]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_bad_op();
        test_imm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
